dmi_reg_responder: RTL and testbench
====================================

DMI_REG_RESPONDER -- requirements
Module: dmi_reg_responder

Interface
REQ-001 SHALL have parameter DmVersion, default 4'd2, the value returned in dmstatus.version.
REQ-002 SHALL have parameter HartInfoValue, default 32'h0, the value returned for hartinfo reads.
REQ-003 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i, input, 1, the reset, synchronous and active-high.
REQ-005 SHALL have port dmi_req_i, input, 41, the request: [40:34] addr, [33:2] data, [1:0] op (0 nop, 1 read, 2 write, 3 reserved).
REQ-006 SHALL have ports dmi_req_valid_i (input, 1) and dmi_req_ready_o (output, 1), the request handshake.
REQ-007 SHALL have port dmi_resp_o, output, 34, the response: [33:2] data, [1:0] resp (0 ok, 2 failed).
REQ-008 SHALL have ports dmi_resp_valid_o (output, 1) and dmi_resp_ready_i (input, 1), the response handshake.
REQ-009 SHALL have port unlock_i, input, 1, the debug-authentication grant from the JTAG password check.
REQ-010 SHALL have port halted_i, input, 1, the hart halted status.
REQ-011 SHALL have ports haltreq_o, resumereq_o, ndmreset_o and dmactive_o, all output, 1, the dmcontrol-driven hart controls.

Function
REQ-012 SHALL implement the FSM IDLE -> EXEC -> RESP -> IDLE; dmi_req_ready_o=1 only in IDLE.
REQ-013 SHALL, on valid&ready in IDLE, capture addr/data/op and go to EXEC; the register access executes in EXEC; RESP is entered one cycle later.
REQ-014 SHALL assert dmi_resp_valid_o only in RESP and hold dmi_resp_o stable until dmi_resp_ready_i=1, then return to IDLE; minimum accept-to-valid latency is 2 cycles.
REQ-015 SHALL keep at most one transaction outstanding; a valid request in EXEC/RESP is not accepted and causes no side effect.
REQ-016 SHALL decode the following addresses:
- 0x04 data0 RW
- 0x05 data1 RW
- 0x10 dmcontrol RW: bit31 haltreq, bit30 resumereq, bit1 ndmreset, bit0 dmactive
- 0x11 dmstatus RO: [3:0] DmVersion, bit7 authenticated, bit9 allhalted=halted_i, bit11 allrunning=~halted_i
- 0x12 hartinfo RO: HartInfoValue
REQ-017 SHALL return data 0 with resp 0 for reads of unmapped addresses; writes to unmapped or RO addresses are ignored with resp 0.
REQ-018 SHALL answer a nop with data 0, resp 0, and op 3 with data 0, resp 2, with no state change.
REQ-019 SHALL return the written value in the data field of a write response.
REQ-020 SHALL, while dmactive=0, force haltreq, resumereq and ndmreset to 0, make data0/data1 read 0, and ignore writes to them; a dmcontrol write with bit0=0 clears all dmcontrol bits.
REQ-021 SHALL make resumereq_o a single-cycle pulse, asserted the cycle after a dmcontrol write with bit30=1 while halted_i=1; resumereq reads back as 0.
REQ-022 SHALL drive haltreq_o, ndmreset_o and dmactive_o directly from the dmcontrol register bits.

Reset
REQ-023 SHALL, while rst_i=1 at a clock edge, clear the FSM to IDLE and clear data0, data1 and dmcontrol to 0.
REQ-024 SHALL drive all of the following to 0 on reset: dmi_resp_valid_o, dmi_resp_o, haltreq_o, resumereq_o, ndmreset_o and dmactive_o.
REQ-025 SHALL drive dmi_req_ready_o to 1 on the cycle after reset.
REQ-026 SHALL drop any in-flight transaction without a response when rst_i is asserted in EXEC or RESP.

Configuration
REQ-027 SHALL, with DMI_AUTH_LOCK_EN defined, fail writes to data0, data1 and dmcontrol while unlock_i=0 (resp 2, no state change); reads stay unaffected and dmstatus.authenticated=unlock_i.
REQ-028 SHALL, without DMI_AUTH_LOCK_EN, ignore unlock_i, allow all writes and read dmstatus.authenticated as 1.

Verification
REQ-029 SHALL check: write dmcontrol 0x00000001, then read 0x11 with halted_i=0 -> dmactive_o=1; dmstatus=0x00000882 (authenticated set, with unlock_i=1 when DMI_AUTH_LOCK_EN is defined).
REQ-030 SHALL check: write data0 0xDEADBEEF with dmactive=1, then read 0x04 -> resp 0, data 0xDEADBEEF; response valid 2 cycles after accept.
REQ-031 SHALL check, with DMI_AUTH_LOCK_EN defined: unlock_i=0, write data1 0x12345678 -> resp 2; read 0x05 -> 0; raising unlock_i and repeating the write -> resp 0.
REQ-032 SHALL check: hold dmi_resp_ready_i=0 for 5 cycles with a second request pending -> response held stable, dmi_req_ready_o=0, second request accepted only after the handshake.
REQ-033 SHALL check: halted_i=1, write dmcontrol 0x40000001 -> resumereq_o high for exactly 1 cycle; read-back of dmcontrol -> 0x00000001.
REQ-034 SHALL check: assert rst_i during EXEC of a write to data0 -> no response, data0=0, dmi_req_ready_o=1 the cycle after reset.

Source files
------------

// File: rtl/dmi_reg_responder.sv
// dmi_reg_responder
// Debug Module Interface register responder. Accepts one DMI request at a
// time, executes the register access, then holds the response until the
// host takes it. Implements data0/data1, dmcontrol, dmstatus and hartinfo.
//
// Optional feature: define DMI_AUTH_LOCK_EN to gate writes to data0, data1
// and dmcontrol on the debug-authentication grant (unlock_i). Without it,
// unlock_i is ignored and the module always reports itself authenticated.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | ready for a request; dmi_req_ready_o high
// EXEC  | captured request executes against the register set
// RESP  | response valid, held stable until dmi_resp_ready_i

module dmi_reg_responder #(
    parameter logic [3:0]  DmVersion     = 4'd2,
    parameter logic [31:0] HartInfoValue = 32'h0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [40:0] dmi_req_i,
    input  logic        dmi_req_valid_i,
    output logic        dmi_req_ready_o,
    output logic [33:0] dmi_resp_o,
    output logic        dmi_resp_valid_o,
    input  logic        dmi_resp_ready_i,
    input  logic        unlock_i,
    input  logic        halted_i,
    output logic        haltreq_o,
    output logic        resumereq_o,
    output logic        ndmreset_o,
    output logic        dmactive_o
);

    localparam logic [6:0] AddrData0     = 7'h04;
    localparam logic [6:0] AddrData1     = 7'h05;
    localparam logic [6:0] AddrDmcontrol = 7'h10;
    localparam logic [6:0] AddrDmstatus  = 7'h11;
    localparam logic [6:0] AddrHartinfo  = 7'h12;

    localparam logic [1:0] OpNop   = 2'd0;
    localparam logic [1:0] OpRead  = 2'd1;
    localparam logic [1:0] OpWrite = 2'd2;

    localparam logic [1:0] RespOk     = 2'd0;
    localparam logic [1:0] RespFailed = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e      state_q;
    logic [6:0]  addr_q;
    logic [31:0] wdata_q;
    logic [1:0]  op_q;

    logic [31:0] data0_q;
    logic [31:0] data1_q;
    logic        haltreq_q;
    logic        ndmreset_q;
    logic        dmactive_q;
    logic        resumereq_q;

    logic [33:0] resp_q;
    logic        resp_valid_q;

    logic        authenticated;

`ifdef DMI_AUTH_LOCK_EN
    assign authenticated = unlock_i;
`else
    // unlock_i has no function in this build; keep it visibly consumed.
    logic unused_unlock;
    assign unused_unlock = unlock_i;
    assign authenticated = 1'b1;
`endif

    logic [31:0] dmstatus;
    logic [31:0] dmcontrol_rd;
    logic [31:0] read_data;
    logic        write_locked;

    // Read mux and write-lock decode for the captured request.
    always_comb begin
        dmstatus     = {20'h0, ~halted_i, 1'b0, halted_i, 1'b0,
                        authenticated, 3'b000, DmVersion};
        // resumereq is a pulse, so it always reads back as 0.
        dmcontrol_rd = {haltreq_q, 29'h0, ndmreset_q, dmactive_q};
        read_data    = 32'h0;
        case (addr_q)
            AddrData0:     read_data = dmactive_q ? data0_q : 32'h0;
            AddrData1:     read_data = dmactive_q ? data1_q : 32'h0;
            AddrDmcontrol: read_data = dmcontrol_rd;
            AddrDmstatus:  read_data = dmstatus;
            AddrHartinfo:  read_data = HartInfoValue;
            default:       read_data = 32'h0;
        endcase
        write_locked = 1'b0;
        if (!authenticated &&
            (addr_q == AddrData0 || addr_q == AddrData1 ||
             addr_q == AddrDmcontrol)) begin
            write_locked = 1'b1;
        end
    end

    // Request/execute/response sequencer with the register file it serves.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            addr_q       <= 7'h0;
            wdata_q      <= 32'h0;
            op_q         <= 2'd0;
            data0_q      <= 32'h0;
            data1_q      <= 32'h0;
            haltreq_q    <= 1'b0;
            ndmreset_q   <= 1'b0;
            dmactive_q   <= 1'b0;
            resumereq_q  <= 1'b0;
            resp_q       <= 34'h0;
            resp_valid_q <= 1'b0;
        end else begin
            resumereq_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (dmi_req_valid_i) begin
                        addr_q  <= dmi_req_i[40:34];
                        wdata_q <= dmi_req_i[33:2];
                        op_q    <= dmi_req_i[1:0];
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    case (op_q)
                        OpNop:  resp_q <= {32'h0, RespOk};
                        OpRead: resp_q <= {read_data, RespOk};
                        OpWrite: begin
                            if (write_locked) begin
                                resp_q <= {wdata_q, RespFailed};
                            end else begin
                                resp_q <= {wdata_q, RespOk};
                                case (addr_q)
                                    AddrData0: begin
                                        if (dmactive_q) data0_q <= wdata_q;
                                    end
                                    AddrData1: begin
                                        if (dmactive_q) data1_q <= wdata_q;
                                    end
                                    AddrDmcontrol: begin
                                        // Clearing dmactive resets the whole
                                        // control word along with it.
                                        if (wdata_q[0]) begin
                                            haltreq_q   <= wdata_q[31];
                                            ndmreset_q  <= wdata_q[1];
                                            dmactive_q  <= 1'b1;
                                            resumereq_q <= wdata_q[30] & halted_i;
                                        end else begin
                                            haltreq_q  <= 1'b0;
                                            ndmreset_q <= 1'b0;
                                            dmactive_q <= 1'b0;
                                        end
                                    end
                                    default: ;
                                endcase
                            end
                        end
                        default: resp_q <= {32'h0, RespFailed};
                    endcase
                    resp_valid_q <= 1'b1;
                    state_q      <= RESP;
                end
                RESP: begin
                    if (dmi_resp_ready_i) begin
                        resp_valid_q <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dmi_req_ready_o  = (state_q == IDLE);
    assign dmi_resp_o       = resp_q;
    assign dmi_resp_valid_o = resp_valid_q;
    assign haltreq_o        = haltreq_q;
    assign resumereq_o      = resumereq_q;
    assign ndmreset_o       = ndmreset_q;
    assign dmactive_o       = dmactive_q;

endmodule

// File: tb/tb_dmi_reg_responder.sv
// Directed bench for dmi_reg_responder with a response scoreboard.
// Honours DMI_AUTH_LOCK_EN the same way the design does.

module tb_dmi_reg_responder;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic [40:0] dmi_req_i = '0;
    logic        dmi_req_valid_i = 1'b0;
    logic        dmi_req_ready_o;
    logic [33:0] dmi_resp_o;
    logic        dmi_resp_valid_o;
    logic        dmi_resp_ready_i = 1'b1;
    logic        unlock_i = 1'b1;
    logic        halted_i = 1'b0;
    logic        haltreq_o, resumereq_o, ndmreset_o, dmactive_o;

    dmi_reg_responder dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .dmi_req_i        (dmi_req_i),
        .dmi_req_valid_i  (dmi_req_valid_i),
        .dmi_req_ready_o  (dmi_req_ready_o),
        .dmi_resp_o       (dmi_resp_o),
        .dmi_resp_valid_o (dmi_resp_valid_o),
        .dmi_resp_ready_i (dmi_resp_ready_i),
        .unlock_i         (unlock_i),
        .halted_i         (halted_i),
        .haltreq_o        (haltreq_o),
        .resumereq_o      (resumereq_o),
        .ndmreset_o       (ndmreset_o),
        .dmactive_o       (dmactive_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int pulse_cnt = 0;
    always @(negedge clk) if (resumereq_o) pulse_cnt <= pulse_cnt + 1;

    typedef struct {
        logic [31:0] d;
        logic [1:0]  r;
    } exp_t;
    exp_t sbq[$];

    int vectors = 0;
    int miscompares = 0;
    int acc_cyc = 0;
    int base;
    logic [33:0] held;

    localparam logic [1:0] RD = 2'd1, WR = 2'd2;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_req(input logic [6:0] a, input logic [31:0] d, input logic [1:0] op);
        @(negedge clk);
        dmi_req_i = {a, d, op};
        dmi_req_valid_i = 1'b1;
    endtask

    task automatic push(input logic [31:0] d, input logic [1:0] r);
        exp_t e;
        e.d = d;
        e.r = r;
        sbq.push_back(e);
    endtask

    // Called at a negedge with the request already driven.
    task automatic wait_accept(input string tag);
        int n = 0;
        while (!dmi_req_ready_o && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_accept"}, dmi_req_ready_o, 1'b1);
        acc_cyc = cyc;
        @(negedge clk);
        dmi_req_valid_i = 1'b0;
    endtask

    task automatic get_resp(input string tag, input bit chk_lat);
        int n = 0;
        exp_t e;
        while (!dmi_resp_valid_o && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, dmi_resp_valid_o, 1'b1);
        if (chk_lat) chk({tag, "_latency"}, cyc - acc_cyc, 2);
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk({tag, "_data"}, dmi_resp_o[33:2], e.d);
            chk({tag, "_resp"}, dmi_resp_o[1:0], e.r);
        end else begin
            chk({tag, "_sb_empty"}, sbq.size(), 1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic xact(input string tag, input logic [6:0] a, input logic [31:0] d,
                        input logic [1:0] op, input logic [31:0] ed, input logic [1:0] er);
        drive_req(a, d, op);
        push(ed, er);
        wait_accept(tag);
        get_resp(tag, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset behaviour
        repeat (3) @(negedge clk);
        chk("rst_resp_valid", dmi_resp_valid_o, 1'b0);
        chk("rst_resp", dmi_resp_o, 34'h0);
        chk("rst_ctrl_outs", {haltreq_o, resumereq_o, ndmreset_o, dmactive_o}, 4'b0000);
        rst_i = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", dmi_req_ready_o, 1'b1);

        // Activate the debug module and read status
        xact("dmctl_wr1", 7'h10, 32'h1, WR, 32'h1, 2'd0);
        chk("dmactive_o", dmactive_o, 1'b1);
        xact("dmstatus_run", 7'h11, 32'h0, RD, 32'h0000_0882, 2'd0);

`ifdef DMI_AUTH_LOCK_EN
        unlock_i = 1'b0;
        xact("lock_wr_data1", 7'h05, 32'h1234_5678, WR, 32'h1234_5678, 2'd2);
        xact("lock_rd_data1", 7'h05, 32'h0, RD, 32'h0, 2'd0);
        xact("lock_dmstatus", 7'h11, 32'h0, RD, 32'h0000_0802, 2'd0);
        xact("lock_wr_dmctl", 7'h10, 32'h0, WR, 32'h0, 2'd2);
        chk("lock_dmactive_kept", dmactive_o, 1'b1);
        unlock_i = 1'b1;
        xact("unlock_wr_data1", 7'h05, 32'h1234_5678, WR, 32'h1234_5678, 2'd0);
`else
        unlock_i = 1'b0;
        xact("nolock_wr_data1", 7'h05, 32'h1234_5678, WR, 32'h1234_5678, 2'd0);
        xact("nolock_dmstatus", 7'h11, 32'h0, RD, 32'h0000_0882, 2'd0);
        unlock_i = 1'b1;
`endif
        xact("rd_data1", 7'h05, 32'h0, RD, 32'h1234_5678, 2'd0);

        // data0 round trip
        xact("wr_data0", 7'h04, 32'hDEAD_BEEF, WR, 32'hDEAD_BEEF, 2'd0);
        xact("rd_data0", 7'h04, 32'h0, RD, 32'hDEAD_BEEF, 2'd0);

        // Read-only, unmapped, nop and reserved op
        xact("rd_hartinfo", 7'h12, 32'h0, RD, 32'h0, 2'd0);
        xact("rd_unmapped", 7'h20, 32'h0, RD, 32'h0, 2'd0);
        xact("wr_unmapped", 7'h20, 32'hA5A5_0001, WR, 32'hA5A5_0001, 2'd0);
        xact("op_nop", 7'h04, 32'hFFFF_FFFF, 2'd0, 32'h0, 2'd0);
        xact("op_rsvd", 7'h04, 32'hFFFF_FFFF, 2'd3, 32'h0, 2'd2);
        xact("rd_data0_after_nop", 7'h04, 32'h0, RD, 32'hDEAD_BEEF, 2'd0);
        xact("wr_dmstatus_ro", 7'h11, 32'hFFFF_FFFF, WR, 32'hFFFF_FFFF, 2'd0);
        halted_i = 1'b1;
        xact("dmstatus_halt", 7'h11, 32'h0, RD, 32'h0000_0282, 2'd0);

        // resumereq pulse only when halted
        halted_i = 1'b0;
        base = pulse_cnt;
        xact("resume_running", 7'h10, 32'h4000_0001, WR, 32'h4000_0001, 2'd0);
        repeat (3) @(negedge clk);
        chk("resume_running_pulses", pulse_cnt - base, 0);
        halted_i = 1'b1;
        base = pulse_cnt;
        xact("resume_halted", 7'h10, 32'h4000_0001, WR, 32'h4000_0001, 2'd0);
        repeat (3) @(negedge clk);
        chk("resume_halted_pulses", pulse_cnt - base, 1);
        xact("rd_dmctl_resume", 7'h10, 32'h0, RD, 32'h0000_0001, 2'd0);
        halted_i = 1'b0;

        // haltreq/ndmreset, then deactivate
        xact("wr_dmctl_halt", 7'h10, 32'h8000_0003, WR, 32'h8000_0003, 2'd0);
        chk("halt_outs", {haltreq_o, ndmreset_o, dmactive_o}, 3'b111);
        xact("rd_dmctl_halt", 7'h10, 32'h0, RD, 32'h8000_0003, 2'd0);
        xact("wr_dmctl_off", 7'h10, 32'h8000_0002, WR, 32'h8000_0002, 2'd0);
        chk("off_outs", {haltreq_o, ndmreset_o, dmactive_o}, 3'b000);
        xact("rd_dmctl_off", 7'h10, 32'h0, RD, 32'h0, 2'd0);
        xact("rd_data0_inactive", 7'h04, 32'h0, RD, 32'h0, 2'd0);
        xact("wr_data0_inactive", 7'h04, 32'h0000_0055, WR, 32'h0000_0055, 2'd0);
        xact("dmctl_reactivate", 7'h10, 32'h1, WR, 32'h1, 2'd0);
        xact("rd_data0_kept", 7'h04, 32'h0, RD, 32'hDEAD_BEEF, 2'd0);

        // Response back-pressure with a second request pending
        dmi_resp_ready_i = 1'b0;
        drive_req(7'h04, 32'h0, RD);
        push(32'hDEAD_BEEF, 2'd0);
        wait_accept("stall_first");
        dmi_req_i = {7'h05, 32'hCAFE_F00D, WR};
        dmi_req_valid_i = 1'b1;
        push(32'hCAFE_F00D, 2'd0);
        for (int n = 0; n < 40 && !dmi_resp_valid_o; n++) @(negedge clk);
        held = dmi_resp_o;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_resp_stable", dmi_resp_o, held);
            chk("stall_resp_valid", dmi_resp_valid_o, 1'b1);
            chk("stall_req_ready", dmi_req_ready_o, 1'b0);
        end
        dmi_resp_ready_i = 1'b1;
        get_resp("stall_first", 1'b0);
        @(negedge clk);
        wait_accept("stall_second");
        get_resp("stall_second", 1'b1);
        xact("rd_data1_after_stall", 7'h05, 32'h0, RD, 32'hCAFE_F00D, 2'd0);

        // Reset in EXEC drops the write
        drive_req(7'h04, 32'h1111_1111, WR);
        wait_accept("rst_exec");
        rst_i = 1'b1;
        @(negedge clk);
        chk("rst_exec_no_valid", dmi_resp_valid_o, 1'b0);
        rst_i = 1'b0;
        @(negedge clk);
        chk("rst_exec_ready", dmi_req_ready_o, 1'b1);
        chk("rst_exec_still_no_valid", dmi_resp_valid_o, 1'b0);
        chk("rst_exec_dmactive", dmactive_o, 1'b0);
        xact("rst_reactivate", 7'h10, 32'h1, WR, 32'h1, 2'd0);
        xact("rst_rd_data0", 7'h04, 32'h0, RD, 32'h0, 2'd0);
        chk("sb_drained", sbq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
